// File: rtl/class_select_ctrl.sv
// class_select_ctrl: time-shared arg-max over a frame of NUM_CLASSES signed class scores.
// Define CLASS_SELECT_MARGIN_EN to also track the runner-up and report a confidence margin.
module class_select_ctrl #(
    parameter int NUM_CLASSES   = 8,
    parameter int SCORE_W       = 11,
    parameter int IDX_W         = $clog2(NUM_CLASSES),
    parameter int MARGIN_THRESH = 16
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      start,
    input  logic                      score_valid,
    output logic                      score_ready,
    input  logic signed [SCORE_W-1:0] score_data,
    output logic                      busy,
    output logic                      result_valid,
    input  logic                      result_ready,
    output logic [IDX_W-1:0]          result_class,
    output logic signed [SCORE_W-1:0] result_score,
    output logic [SCORE_W:0]          result_margin,
    output logic                      result_low_conf
);
    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_t                    state;
    logic [IDX_W-1:0]          count;
    logic [IDX_W-1:0]          best_idx;
    logic signed [SCORE_W-1:0] best_score;
    logic                      accept;
    logic                      new_best;

    // score_ready is only high in COLLECT, so a COLLECT-state valid is a handshake.
    assign accept   = (state == COLLECT) && score_valid;
    // The first score of a frame always wins; later ties go to the higher index.
    assign new_best = (count == '0) || (score_data >= best_score);

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others, as real flops do.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            // NOTE: best_idx/best_score drive result ports directly, so they are
            // reset too; a mid-frame reset must leave no stale result visible.
            state        <= IDLE;
            count        <= '0;
            best_idx     <= '0;
            best_score   <= '0;
            score_ready  <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= COLLECT;
                        count       <= '0;
                        score_ready <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        if (new_best) begin
                            best_score <= score_data;
                            best_idx   <= count;
                        end
                        if (count == LAST_IDX) begin
                            state        <= DONE;
                            score_ready  <= 1'b0;
                            result_valid <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state        <= IDLE;
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    score_ready  <= 1'b0;
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

    assign result_class = best_idx;
    assign result_score = best_score;

`ifdef CLASS_SELECT_MARGIN_EN
    localparam logic signed [SCORE_W-1:0] MIN_SCORE = {1'b1, {(SCORE_W-1){1'b0}}};
    localparam logic [SCORE_W:0]          THRESH    = (SCORE_W+1)'(MARGIN_THRESH);

    logic signed [SCORE_W-1:0] second_score;
    logic [SCORE_W:0]          margin;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            second_score <= MIN_SCORE;
        end else if (accept) begin
            if (count == '0) begin
                second_score <= MIN_SCORE;
            end else if (new_best) begin
                second_score <= best_score;
            end else if (score_data > second_score) begin
                second_score <= score_data;
            end
        end
    end

    // best >= second always holds, so the sign-extended difference is non-negative.
    assign margin          = {best_score[SCORE_W-1], best_score}
                           - {second_score[SCORE_W-1], second_score};
    assign result_margin   = result_valid ? margin : '0;
    assign result_low_conf = result_valid && (margin < THRESH);
`else
    assign result_margin   = '0;
    assign result_low_conf = 1'b0;
`endif

endmodule

// File: tb/tb_class_select_ctrl.sv
// Self-checking bench for class_select_ctrl: expected results are queued per frame
// and popped when the controller presents its result.
module tb_class_select_ctrl;
    localparam int NUM_CLASSES = 8;
    localparam int SCORE_W     = 11;
    localparam int IDX_W       = 3;

    typedef struct {
        logic [IDX_W-1:0]          cls;
        logic signed [SCORE_W-1:0] score;
        logic [SCORE_W:0]          margin;
        logic                      low_conf;
    } exp_t;

    logic                      Clk;
    logic                      Reset_n;
    logic                      start;
    logic                      score_valid;
    logic                      score_ready;
    logic signed [SCORE_W-1:0] score_data;
    logic                      busy;
    logic                      result_valid;
    logic                      result_ready;
    logic [IDX_W-1:0]          result_class;
    logic signed [SCORE_W-1:0] result_score;
    logic [SCORE_W:0]          result_margin;
    logic                      result_low_conf;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    class_select_ctrl dut (
        .Clk             (Clk),
        .Reset_n         (Reset_n),
        .start           (start),
        .score_valid     (score_valid),
        .score_ready     (score_ready),
        .score_data      (score_data),
        .busy            (busy),
        .result_valid    (result_valid),
        .result_ready    (result_ready),
        .result_class    (result_class),
        .result_score    (result_score),
        .result_margin   (result_margin),
        .result_low_conf (result_low_conf)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Reference: arg-max with ties to the higher index; runner-up is the best of the rest.
    function automatic exp_t model(input int v[NUM_CLASSES]);
        exp_t e;
        int   bi;
        int   runner;
        bi     = 0;
        runner = -(1 << (SCORE_W - 1));
        for (int i = 1; i < NUM_CLASSES; i++)
            if (v[i] >= v[bi]) bi = i;
        for (int i = 0; i < NUM_CLASSES; i++)
            if (i != bi && v[i] > runner) runner = v[i];
        e.cls   = IDX_W'(bi);
        e.score = SCORE_W'(v[bi]);
`ifdef CLASS_SELECT_MARGIN_EN
        e.margin   = (SCORE_W+1)'(v[bi] - runner);
        e.low_conf = ((v[bi] - runner) < 16);
`else
        e.margin   = '0;
        e.low_conf = 1'b0;
`endif
        return e;
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Drives one frame and retires its result. hold = cycles result_ready stays low.
    task automatic run_frame(input string name, input int v[NUM_CLASSES], input bit gaps,
                             input int hold, input bit poke_start);
        exp_t e;
        int   waited;
        sb.push_back(model(v));
        result_ready = (hold == 0);
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (score_ready !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s start_to_ready: ready=%b busy=%b want 1 1", name, score_ready, busy);
        end
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                repeat (g) begin
                    score_valid = 1'b0;
                    start = poke_start;
                    step();
                    start = 1'b0;
                end
            end
            score_valid = 1'b1;
            score_data  = SCORE_W'(v[i]);
            step();
        end
        score_valid = 1'b0;
        checks++;
        if (result_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s result_latency: result_valid=%b want 1", name, result_valid);
        end
        waited = 0;
        while (result_valid !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        e = sb.pop_front();
        checks++;
        if (result_class !== e.cls) begin
            failures++;
            $display("FAIL %s class: got %0d want %0d", name, result_class, e.cls);
        end
        checks++;
        if (result_score !== e.score) begin
            failures++;
            $display("FAIL %s score: got %0d want %0d", name, result_score, e.score);
        end
        checks++;
        if (result_margin !== e.margin) begin
            failures++;
            $display("FAIL %s margin: got %0d want %0d", name, result_margin, e.margin);
        end
        checks++;
        if (result_low_conf !== e.low_conf) begin
            failures++;
            $display("FAIL %s low_conf: got %b want %b", name, result_low_conf, e.low_conf);
        end
        repeat (hold) begin
            start = poke_start;
            step();
            start = 1'b0;
            checks++;
            if (result_valid !== 1'b1 || result_class !== e.cls || result_score !== e.score
                || result_margin !== e.margin) begin
                failures++;
                $display("FAIL %s hold_stable: valid=%b class=%0d score=%0d margin=%0d want 1 %0d %0d %0d",
                         name, result_valid, result_class, result_score, result_margin,
                         e.cls, e.score, e.margin);
            end
        end
        result_ready = 1'b1;
        start = poke_start;
        step();
        start = 1'b0;
        result_ready = 1'b0;
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || score_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s idle_after_handshake: valid=%b busy=%b ready=%b want 0 0 0",
                     name, result_valid, busy, score_ready);
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        start = 1'b0;
        score_valid = 1'b0;
        score_data = '0;
        result_ready = 1'b0;
        repeat (3) step();
        checks++;
        if ({score_ready, busy, result_valid, result_class, result_score, result_margin,
             result_low_conf} !== '0) begin
            failures++;
            $display("FAIL reset_values: ready=%b busy=%b valid=%b class=%0d score=%0d margin=%0d low=%b want all 0",
                     score_ready, busy, result_valid, result_class, result_score,
                     result_margin, result_low_conf);
        end
        Reset_n = 1'b1;
        step();
        checks++;
        if (score_ready !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: ready=%b busy=%b valid=%b want 0 0 0",
                     score_ready, busy, result_valid);
        end
    endtask

    task automatic test_ascending();
        run_frame("ascending", '{0, 10, 20, 30, 40, 50, 60, 70}, 1'b0, 0, 1'b0);
    endtask

    task automatic test_negative();
        run_frame("negative", '{-5, -300, -1, -1024, -2, -7, -9, -3}, 1'b0, 0, 1'b0);
    endtask

    task automatic test_tie();
        run_frame("tie", '{5, 9, 9, 0, 9, 1, 2, 3}, 1'b0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_frame("b2b_a", '{1023, 1023, -1024, 0, 5, 5, 6, -6}, 1'b0, 0, 1'b0);
        run_frame("b2b_b", '{-1024, -1024, -1024, -1024, -1024, -1024, -1024, -1024}, 1'b0, 0, 1'b0);
    endtask

    task automatic test_gaps_hold();
        int v[NUM_CLASSES];
        run_frame("gaps_fixed", '{3, -8, 77, 12, 77, -500, 40, 6}, 1'b1, 5, 1'b1);
        for (int i = 0; i < NUM_CLASSES; i++) v[i] = int'($urandom_range(0, 2047)) - 1024;
        run_frame("gaps_random", v, 1'b1, 5, 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            score_valid = 1'b1;
            score_data  = SCORE_W'(400 + i);
            step();
        end
        score_valid = 1'b0;
        Reset_n = 1'b0;
        #1;
        checks++;
        if ({score_ready, busy, result_valid, result_class, result_score, result_margin,
             result_low_conf} !== '0) begin
            failures++;
            $display("FAIL mid_frame_reset: ready=%b busy=%b valid=%b class=%0d score=%0d want all 0",
                     score_ready, busy, result_valid, result_class, result_score);
        end
        step();
        Reset_n = 1'b1;
        repeat (4) step();
        checks++;
        if (result_valid !== 1'b0 || score_ready !== 1'b0) begin
            failures++;
            $display("FAIL no_result_after_reset: valid=%b ready=%b want 0 0", result_valid, score_ready);
        end
        run_frame("after_reset", '{100, -1024, 1023, 0, 0, 0, 0, 0}, 1'b0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_negative();
        test_tie();
        test_back_to_back();
        test_gaps_hold();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
